// File: rtl/t06_sound_sequencer.sv
// Sound-effect sequencer: fixed-priority arbitration with preemption and pending
// latches, stepping each effect through a small note table onto the PWM tone path.
module t06_sound_sequencer #(
  parameter int NOTE_TICKS = 2500000,
  parameter int GAP_TICKS  = 500000,
  parameter int CNT_W      = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [5:0] note,
  output logic       pwm_enable,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
  localparam logic             NO_GAP    = (GAP_TICKS == 0);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  function automatic logic [5:0] note_lut(input logic [1:0] id, input logic [1:0] slot);
    logic [5:0] n;
    case ({id, slot})
      4'b00_00: n = 6'd30;
      4'b00_01: n = 6'd25;
      4'b00_10: n = 6'd20;
      4'b00_11: n = 6'd15;
      4'b01_00: n = 6'd12;
      4'b01_01: n = 6'd8;
      4'b10_00: n = 6'd24;
      4'b10_01: n = 6'd32;
      default:  n = 6'd0;
    endcase
    return n;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       slot_r, slot_s;
  logic [1:0]       id_r, id_s;
  logic [2:0]       pending_r, pending_s;
  logic             done_s, start_s, finish_s;
  logic [2:0]       active_mask_s, cand_s, win_mask_s;
  logic [1:0]       win_s;
  logic             has_win_s, preempt_s, note_end_s, gap_end_s, last_slot_s;

  // Arbitration: the active effect's own requests are masked out before selection.
  always_comb begin
    if (state_r != ST_IDLE) begin
      active_mask_s = 3'b001 << id_r;
    end else begin
      active_mask_s = 3'b000;
    end
    cand_s    = (req & ~active_mask_s) | pending_r;
    has_win_s = |cand_s;
    if (cand_s[0]) begin
      win_s = 2'd0; win_mask_s = 3'b001;
    end else if (cand_s[1]) begin
      win_s = 2'd1; win_mask_s = 3'b010;
    end else if (cand_s[2]) begin
      win_s = 2'd2; win_mask_s = 3'b100;
    end else begin
      win_s = 2'd0; win_mask_s = 3'b000;
    end
    preempt_s   = has_win_s && (win_s < id_r);
    note_end_s  = (cnt_r == NOTE_LAST);
    gap_end_s   = (cnt_r == GAP_LAST);
    last_slot_s = (slot_r == 2'd3) || (note_lut(id_r, slot_r + 2'd1) == 6'd0);
  end

  // Next-state sequencing; natural completion outranks preemption on the same edge.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r + CNT_ONE;
    slot_s   = slot_r;
    id_s     = id_r;
    done_s   = 1'b0;
    start_s  = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s   = CNT_ZERO;
        start_s = has_win_s;
      end
      ST_PLAY: begin
        finish_s = note_end_s && NO_GAP && last_slot_s;
        if (preempt_s) begin
          start_s = 1'b1;
        end else if (note_end_s) begin
          cnt_s = CNT_ZERO;
          if (NO_GAP) begin
            slot_s = slot_r + 2'd1;
          end else begin
            state_s = ST_GAP;
          end
        end else begin
          start_s = 1'b0;
        end
      end
      ST_GAP: begin
        finish_s = gap_end_s && last_slot_s;
        if (preempt_s) begin
          start_s = 1'b1;
        end else if (gap_end_s) begin
          state_s = ST_PLAY;
          slot_s  = slot_r + 2'd1;
          cnt_s   = CNT_ZERO;
        end else begin
          start_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        slot_s  = 2'd0;
        id_s    = 2'd0;
      end
    endcase
    if (finish_s) begin
      done_s  = 1'b1;
      state_s = ST_IDLE;
      cnt_s   = CNT_ZERO;
      slot_s  = 2'd0;
      id_s    = 2'd0;
      start_s = has_win_s;
    end else begin
      done_s = 1'b0;
    end
    if (start_s) begin
      state_s = ST_PLAY;
      cnt_s   = CNT_ZERO;
      slot_s  = 2'd0;
      id_s    = win_s;
    end else begin
      id_s = id_s;
    end
    pending_s = (pending_r | (req & ~active_mask_s)) & ~(start_s ? win_mask_s : 3'b000);
  end

  // State and registered outputs, all derived from the next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      slot_r     <= 2'd0;
      id_r       <= 2'd0;
      pending_r  <= 3'b000;
      note       <= 6'd0;
      pwm_enable <= 1'b0;
      busy       <= 1'b0;
      active_id  <= 2'd0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      slot_r     <= slot_s;
      id_r       <= id_s;
      pending_r  <= pending_s;
      note       <= (state_s == ST_PLAY) ? note_lut(id_s, slot_s) : 6'd0;
      pwm_enable <= (state_s == ST_PLAY);
      busy       <= (state_s != ST_IDLE);
      active_id  <= (state_s != ST_IDLE) ? id_s : 2'd0;
      done       <= done_s;
    end
  end

endmodule

// File: tb/tb_t06_sound_sequencer.sv
// Bench for t06_sound_sequencer: directed scenarios plus random traffic checked
// against a timeline-based reference model (effect id + elapsed cycles).
module tb_t06_sound_sequencer;

  localparam int NT = 4;
  localparam int GT = 2;
  localparam int P  = NT + GT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [5:0] note;
  logic       pwm_enable, busy, done;
  logic [1:0] active_id;
  logic [10:0] dut_vec;

  int n_vec = 0;
  int n_err = 0;

  int tbl [0:2][0:3] = '{'{30, 25, 20, 15}, '{12, 8, 0, 0}, '{24, 32, 0, 0}};
  int         m_cur  = -1;
  int         m_t    = 0;
  logic [2:0] m_pend = 3'b000;
  logic       m_done = 1'b0;

  t06_sound_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .note(note), .pwm_enable(pwm_enable),
    .busy(busy), .active_id(active_id), .done(done)
  );

  assign dut_vec = {note, pwm_enable, busy, active_id, done};

  always #5 clk = ~clk;

  function automatic int eff_len(input int id);
    int n = 0;
    for (int s = 0; s < 4; s++) begin
      if (tbl[id][s] == 0) break;
      n++;
    end
    return n * P;
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [5:0] n;
    logic       pw;
    int         ph, sl;
    if (m_cur < 0) return {6'd0, 1'b0, 1'b0, 2'd0, m_done};
    ph = m_t % P;
    sl = m_t / P;
    pw = (ph < NT);
    n  = pw ? 6'(tbl[m_cur][sl]) : 6'd0;
    return {n, pw, 1'b1, 2'(m_cur), m_done};
  endfunction

  // Drive one cycle of inputs, advance the reference model at the edge, sample 1 ns later.
  task automatic step(input logic [2:0] r, input logic rs);
    logic [2:0] mask, cand;
    int win, started;
    @(negedge clk);
    req = r;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      m_cur = -1; m_t = 0; m_pend = 3'b000; m_done = 1'b0;
    end else begin
      mask    = (m_cur >= 0) ? (3'b001 << m_cur) : 3'b000;
      cand    = (r & ~mask) | m_pend;
      win     = cand[0] ? 0 : cand[1] ? 1 : cand[2] ? 2 : -1;
      started = -1;
      m_done  = 1'b0;
      if (m_cur < 0) begin
        if (win >= 0) started = win;
      end else if (m_t == eff_len(m_cur) - 1) begin
        m_done = 1'b1;
        if (win >= 0) started = win;
        else m_cur = -1;
      end else if (win >= 0 && win < m_cur) begin
        started = win;
      end else begin
        m_t++;
      end
      m_pend = m_pend | (r & ~mask);
      if (started >= 0) begin
        m_cur = started;
        m_t = 0;
        m_pend[started] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(3'b111, 1'b1);
    step(3'b111, 1'b1);
    n_vec++;
    if (dut_vec !== 11'd0) begin
      n_err++; $display("FAIL reset_hold got=%h want=%h", dut_vec, 11'd0);
    end
    step(3'b000, 1'b0);
    n_vec++;
    if (dut_vec !== 11'd0) begin
      n_err++; $display("FAIL reset_release got=%h want=%h", dut_vec, 11'd0);
    end
  endtask

  task automatic test_single();
    step(3'b100, 1'b0);
    n_vec++;
    if ({note, pwm_enable, busy, active_id} !== {6'd24, 1'b1, 1'b1, 2'd2}) begin
      n_err++; $display("FAIL single_first got=%h want=%h", {note, pwm_enable, busy, active_id}, {6'd24, 1'b1, 1'b1, 2'd2});
    end
    for (int i = 1; i < 12; i++) begin
      step(3'b000, 1'b0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL single_seq cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    step(3'b000, 1'b0);
    n_vec++;
    if ({done, busy} !== 2'b10) begin
      n_err++; $display("FAIL single_done got=%b want=%b", {done, busy}, 2'b10);
    end
  endtask

  task automatic test_simultaneous();
    step(3'b110, 1'b0);
    n_vec++;
    if ({note, active_id} !== {6'd12, 2'd1}) begin
      n_err++; $display("FAIL simul_first got=%h want=%h", {note, active_id}, {6'd12, 2'd1});
    end
    for (int i = 1; i < 12; i++) begin
      step(3'b000, 1'b0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL simul_seq cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    step(3'b000, 1'b0);
    n_vec++;
    if ({done, busy, note, active_id} !== {1'b1, 1'b1, 6'd24, 2'd2}) begin
      n_err++; $display("FAIL simul_chain got=%h want=%h", {done, busy, note, active_id}, {1'b1, 1'b1, 6'd24, 2'd2});
    end
    for (int i = 0; i < 12; i++) begin
      step(3'b000, 1'b0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL simul_tail cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_preempt();
    step(3'b100, 1'b0);
    step(3'b000, 1'b0);
    n_vec++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL preempt_pre got=%h want=%h", dut_vec, exp_vec());
    end
    step(3'b001, 1'b0);
    n_vec++;
    if ({note, active_id, done} !== {6'd30, 2'd0, 1'b0}) begin
      n_err++; $display("FAIL preempt_switch got=%h want=%h", {note, active_id, done}, {6'd30, 2'd0, 1'b0});
    end
    for (int i = 1; i < 24; i++) begin
      step(3'b000, 1'b0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL preempt_seq cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    step(3'b000, 1'b0);
    n_vec++;
    if ({done, busy} !== 2'b10) begin
      n_err++; $display("FAIL preempt_done got=%b want=%b", {done, busy}, 2'b10);
    end
    for (int i = 0; i < 8; i++) begin
      step(3'b000, 1'b0);
      n_vec++;
      if (dut_vec !== 11'd0) begin
        n_err++; $display("FAIL preempt_no_resume cyc=%0d got=%h want=%h", i, dut_vec, 11'd0);
      end
    end
  endtask

  task automatic test_busy_request();
    step(3'b001, 1'b0);
    n_vec++;
    if ({note, active_id} !== {6'd30, 2'd0}) begin
      n_err++; $display("FAIL busy_first got=%h want=%h", {note, active_id}, {6'd30, 2'd0});
    end
    for (int i = 1; i < 24; i++) begin
      step((i == 3) ? 3'b010 : (i == 9) ? 3'b001 : 3'b000, 1'b0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL busy_seq cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    step(3'b000, 1'b0);
    n_vec++;
    if ({done, note, active_id} !== {1'b1, 6'd12, 2'd1}) begin
      n_err++; $display("FAIL busy_handoff got=%h want=%h", {done, note, active_id}, {1'b1, 6'd12, 2'd1});
    end
    for (int i = 0; i < 12; i++) begin
      step(3'b000, 1'b0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL busy_tail cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    step(3'b010, 1'b0);
    step(3'b100, 1'b0);
    step(3'b000, 1'b0);
    step(3'b000, 1'b1);
    n_vec++;
    if (dut_vec !== 11'd0) begin
      n_err++; $display("FAIL reset_mid got=%h want=%h", dut_vec, 11'd0);
    end
    for (int i = 0; i < 20; i++) begin
      step(3'b000, 1'b0);
      n_vec++;
      if (dut_vec !== 11'd0) begin
        n_err++; $display("FAIL reset_mid_idle cyc=%0d got=%h want=%h", i, dut_vec, 11'd0);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic       rs;
    for (int i = 0; i < 4000; i++) begin
      r[0] = ($urandom_range(0, 23) == 0);
      r[1] = ($urandom_range(0, 15) == 0);
      r[2] = ($urandom_range(0, 11) == 0);
      rs   = ($urandom_range(0, 399) == 0);
      step(r, rs);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random cyc=%0d req=%b got=%h want=%h", i, r, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_busy_request();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/t06_sound_sequencer.md
Name: t06_sound_sequencer

Overview:
- Schedules sound effects onto the shared PWM tone datapath.
- Takes one-cycle event requests from game logic: game-over, bad collision and good collision.
- Arbitrates requests by fixed priority, with preemption and pending latches.
- Steps each effect through a short internal note table, driving the note index and gate into the PWM tone generator.

Parameters:
- NOTE_TICKS, default 2500000: clock cycles each note is held; legal range >= 1.
- GAP_TICKS, default 500000: silent clock cycles after each note; legal range >= 0, and 0 skips the gap.
- CNT_W, default 22: width of the tick counter; must hold max(NOTE_TICKS, GAP_TICKS).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  3  effect requests, sampled every edge. bit0 = game over (highest priority), bit1 = bad collision, bit2 = good collision (lowest priority).
- note  out  6  note index to the PWM lookup; 0 = silence.
- pwm_enable  out  1  tone gate to the PWM counter.
- busy  out  1  high while not in IDLE.
- active_id  out  2  effect currently sequenced; 0 when idle.
- done  out  1  one-cycle pulse when an effect completes naturally.

Behaviour:
- Reset: rst sampled high at an edge gives, from the next cycle:
  - state IDLE, counter 0, slot 0, pending 0;
  - note 0, pwm_enable 0, busy 0, active_id 0, done 0.
  - Reset overrides everything, including mid-note.
- Note table: 4 slots per effect; a value of 0 terminates the effect early. A full 4-slot effect ends after slot 3.
  - Effect 0: 30, 25, 20, 15.
  - Effect 1: 12, 8, 0, 0.
  - Effect 2: 24, 32, 0, 0.
- Pending register (3 bits): each edge sets pending[i] |= req[i], except:
  - a request for the effect currently active is ignored;
  - a request that starts or preempts in the same edge does not set pending.
- Selection: the winner is the lowest index among (req | pending).
  - Starting an effect clears its pending bit.
- States:
  - IDLE: if a winner exists, go to PLAY at slot 0, counter 0, active_id = winner.
  - PLAY: note = table[id][slot], pwm_enable = 1. Stays exactly NOTE_TICKS cycles, then goes to GAP; if GAP_TICKS = 0, the GAP step is skipped and the end-of-gap handling runs directly.
  - GAP: note 0, pwm_enable 0, for GAP_TICKS cycles. At the end of the gap:
    - if slot < 3 and the next table entry is nonzero, go to PLAY at slot+1;
    - otherwise the effect is complete: pulse done, then either start the pending winner directly in PLAY (no IDLE cycle) or go to IDLE.
- Latency: a request sampled at edge k in IDLE gives note/pwm_enable valid in cycle k+1.
- Preemption: in PLAY or GAP, a winner with strictly lower index than active_id starts immediately.
  - Slot and counter reset; the next cycle shows the new first note.
  - The preempted effect is dropped: no done, no resume, pending bit stays clear.
- Simultaneous events:
  - Several requests at once: the lowest index wins and the rest become pending.
  - Completion coinciding with a new request: done pulses, and the winner among (req | pending) starts in the same cycle.
- Outputs are registered; done is high for exactly one cycle per natural completion.
- Counter: CNT_W bits, cleared on every state or slot change, never wraps under legal parameters.

Test Plan (NOTE_TICKS=4, GAP_TICKS=2 throughout):
1. Reset: rst high 2 cycles with req=3'b111 -> all outputs 0, and still 0 in the first cycle after rst drops (pending was not latched during reset).
2. Single effect: one-cycle req=3'b100 in IDLE.
   - Next cycle: note=24, pwm_enable=1, active_id=2, busy=1.
   - Then: 4 cycles tone, 2 cycles silent, note=32 for 4 cycles, 2 silent.
   - done=1 and busy=0 exactly 12 cycles after the first note cycle.
3. Simultaneous requests: req=3'b110 in IDLE.
   - Note 12 plays first (active_id=1), then note 8.
   - done pulses in the same cycle that note=24 appears, with active_id=2 and no IDLE cycle between.
4. Preemption: during effect 2's first note (cycle 2), pulse req[0].
   - Next cycle: note=30, active_id=0, no done pulse.
   - After effect 0's 4 notes: done, then IDLE; effect 2 never resumes.
5. Lower request while busy: during effect 0, pulse req[1] and re-pulse req[0].
   - Effect 0 continues uninterrupted and is not restarted.
   - After its done, effect 1 plays note 12 immediately.
6. Reset mid-operation: rst during a PLAY cycle with pending=3'b100.
   - Next cycle: all outputs 0.
   - After rst drops, remains IDLE (pending cleared).
